// File: rtl/cla_serial_adder.sv
// Serial adder/subtractor: one 4-bit carry-lookahead group per clock, LSB group first.
// Results are published only on entry to DONE; busy/done mirror the FSM state.
module cla_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept_c, last_c;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_nxt_c;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  logic [3:0] ga_c, gb_c, g_c, p_c, gsum_c;
  logic [4:0] c_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is honoured only in IDLE and DONE
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          accept_c  = 1'b1;
        end
      end
      BUSY: begin
        if (idx_q == LAST) begin
          state_nxt = DONE;
          last_c    = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = BUSY;
          accept_c  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // 4-bit lookahead group on the low nibble of the shifting operand registers
  always_comb begin
    ga_c   = a_q[3:0];
    gb_c   = b_q[3:0];
    g_c    = ga_c & gb_c;
    p_c    = ga_c ^ gb_c;
    c_c[0] = carry_q;
    c_c[1] = g_c[0] | (p_c[0] & carry_q);
    c_c[2] = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & carry_q);
    c_c[3] = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
           | (p_c[2] & p_c[1] & p_c[0] & carry_q);
    c_c[4] = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
           | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
           | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & carry_q);
    gsum_c = p_c ^ c_c[3:0];
    // New group enters at the top; after N shifts the word is fully aligned
    work_nxt_c = (work_q >> 4) | (WIDTH'(gsum_c) << (WIDTH - 4));
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      busy <= (state_nxt == BUSY);
      done <= (state_nxt == DONE);
      if (accept_c) begin
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub | cin;
        work_q  <= '0;
        idx_q   <= '0;
      end else if (state == BUSY) begin
        a_q     <= a_q >> 4;
        b_q     <= b_q >> 4;
        carry_q <= c_c[4];
        work_q  <= work_nxt_c;
        idx_q   <= idx_q + IW'(1);
        // In the MSB group c3 is the carry into bit WIDTH-1
        if (last_c) begin
          sum  <= work_nxt_c;
          cout <= c_c[4];
          ovf  <= c_c[3] ^ c_c[4];
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboard bench for cla_serial_adder: 16-bit and 4-bit instances, directed and random operations.
module tb_cla_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s16, c16, sb16, bz16, dn16, co16, ov16;
  logic [15:0] a16, b16, sm16;
  logic        s4, c4, sb4, bz4, dn4, co4, ov4;
  logic [3:0]  a4, b4, sm4;

  cla_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16), .cin(c16), .sub(sb16),
    .busy(bz16), .done(dn16), .sum(sm16), .cout(co16), .ovf(ov16));

  cla_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .cin(c4), .sub(sb4),
    .busy(bz4), .done(dn4), .sum(sm4), .cout(co4), .ovf(ov4));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [15:0] p16;
  logic [3:0]  p4;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic and sign rules
  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic ci, logic sb, int acc);
    exp_t e;
    int unsigned m, ua, ub, r;
    bit sa, sbb, sr;
    m  = (32'd1 << w) - 32'd1;
    ua = 32'(a) & m;
    ub = 32'(b) & m;
    if (sb) begin
      r      = (ua - ub) & m;
      e.cout = (ua >= ub);
    end else begin
      r      = ua + ub + 32'(ci);
      e.cout = ((r >> w) != 0);
      r      = r & m;
    end
    sa  = ((ua >> (w - 1)) & 32'd1) != 0;
    sbb = ((ub >> (w - 1)) & 32'd1) != 0;
    sr  = ((r  >> (w - 1)) & 32'd1) != 0;
    e.ovf = sb ? ((sa != sbb) && (sr != sa)) : ((sa == sbb) && (sr != sa));
    e.sum = 16'(r);
    e.cyc = acc + w / 4;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic drive(int sel, logic st, logic [15:0] a, logic [15:0] b, logic ci, logic sb);
    if (sel == 0) begin
      s16 = st; a16 = a; b16 = b; c16 = ci; sb16 = sb;
    end else begin
      s4 = st; a4 = a[3:0]; b4 = b[3:0]; c4 = ci; sb4 = sb;
    end
  endtask

  // Call at a negedge; returns just after the accepting edge
  task automatic issue(int sel, logic [15:0] a, logic [15:0] b, logic ci, logic sb);
    drive(sel, 1'b1, a, b, ci, sb);
    @(posedge clk);
    #1;
    if (sel == 0) q16.push_back(model(16, a, b, ci, sb, cyc));
    else          q4.push_back(model(4, a, b, ci, sb, cyc));
    drive(sel, 1'b0, a, b, ci, sb);
  endtask

  // Returns at the negedge where done is seen; optionally scribbles on inputs while busy
  task automatic wait_done(int sel, bit junk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((sel == 0) ? dn16 : dn4) return;
      if (junk) drive(sel, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    tests++;
    fails++;
    $display("FAIL timeout%0d: got no done, expected done within 40 cycles", sel);
  endtask

  task automatic mon(int sel);
    exp_t e;
    logic d, co, ov;
    logic [15:0] s;
    d  = (sel == 0) ? dn16 : dn4;
    s  = (sel == 0) ? sm16 : {12'b0, sm4};
    co = (sel == 0) ? co16 : co4;
    ov = (sel == 0) ? ov16 : ov4;
    if (!d) return;
    if ((sel == 0 && q16.size() == 0) || (sel == 1 && q4.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL spurious_done%0d: got done=1, expected no pending operation", sel);
      return;
    end
    if (sel == 0) e = q16.pop_front();
    else          e = q4.pop_front();
    chk(sel == 0 ? "sum16" : "sum4", 32'(s), 32'(e.sum));
    chk(sel == 0 ? "cout16" : "cout4", 32'(co), 32'(e.cout));
    chk(sel == 0 ? "ovf16" : "ovf4", 32'(ov), 32'(e.ovf));
    chk(sel == 0 ? "latency16" : "latency4", 32'(cyc), 32'(e.cyc));
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Published results may only move on a done cycle
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p16 = '0;
      p4  = '0;
    end else begin
      if (!dn16) chk("hold16", 32'(sm16), 32'(p16));
      if (!dn4)  chk("hold4", 32'(sm4), 32'(p4));
      p16 = sm16;
      p4  = sm4;
    end
  end

  task automatic random_ops(int sel, int count);
    for (int k = 0; k < count; k++) begin
      issue(sel, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      wait_done(sel, 1'b1);
      if ($urandom_range(1, 0) == 1) begin
        drive(sel, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        repeat ($urandom_range(2, 1)) @(negedge clk);
      end
    end
    drive(sel, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bz16), 32'd0);
    chk("rst_done", 32'(dn16), 32'd0);
    chk("rst_sum", 32'(sm16), 32'd0);
    chk("rst_cout", 32'(co16), 32'd0);
    chk("rst_ovf", 32'(ov16), 32'd0);
    rst_n = 1'b1;

    // First edge after release must accept; busy exactly four cycles
    issue(0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_window", 32'(bz16), 32'd1);
      chk("done_early", 32'(dn16), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(dn16), 32'd1);
    chk("busy_after", 32'(bz16), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(dn16), 32'd0);

    issue(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0); wait_done(0, 1'b0);
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_done(0, 1'b0);
    issue(0, 16'h0005, 16'h0007, 1'b1, 1'b1); wait_done(0, 1'b0);
    issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1); wait_done(0, 1'b0);

    // Start pulse during busy is ignored; start held in DONE chains the next op
    issue(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'hFFFF, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'hFFFF, 16'h1111, 1'b0, 1'b0);
    wait_done(0, 1'b0);
    issue(0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_busy", 32'(bz16), 32'd1);
    wait_done(0, 1'b0);
    @(negedge clk);

    random_ops(0, 150);
    @(negedge clk);

    // Reset mid-operation abandons it
    issue(0, 16'h1234, 16'h1111, 1'b0, 1'b0); wait_done(0, 1'b0);
    @(negedge clk);
    issue(0, 16'h4321, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bz16), 32'd0);
    chk("arst_done", 32'(dn16), 32'd0);
    chk("arst_sum", 32'(sm16), 32'd0);
    chk("arst_cout", 32'(co16), 32'd0);
    q16.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(dn16), 32'd0);
    end

    // Narrow instance: a single group per operation
    issue(1, 16'h000B, 16'h000B, 1'b0, 1'b0); wait_done(1, 1'b0);
    issue(1, 16'h000F, 16'h000F, 1'b1, 1'b0); wait_done(1, 1'b0);
    @(negedge clk);
    random_ops(1, 60);

    repeat (4) @(negedge clk);
    chk("q16_drained", 32'(q16.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cla_serial_adder.md
CLA_SERIAL_ADDER -- requirements
Module: cla_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and >= 4.
REQ-002 Derived constant N = WIDTH/4, the number of 4-bit lookahead groups; SHALL equal the cycles spent in BUSY.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 a  input  WIDTH  operand A; captured when start is accepted.
REQ-007 b  input  WIDTH  operand B; captured when start is accepted.
REQ-008 cin  input  1  carry-in for add; captured when start is accepted.
REQ-009 sub  input  1  0 = add, 1 = subtract; captured when start is accepted.
REQ-010 busy  output  1  high while a computation is in progress.
REQ-011 done  output  1  one-cycle pulse marking sum/cout/ovf as updated.
REQ-012 sum  output  WIDTH  registered result.
REQ-013 cout  output  1  registered carry-out of MSB group.
REQ-014 ovf  output  1  registered two's-complement overflow flag.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-016 IDLE: start=1 at an edge SHALL capture a, b, cin, sub, clear group index to 0, and enter BUSY; start=0 stays IDLE.
REQ-017 Add (sub=0) SHALL compute a + b + cin; subtract (sub=1) SHALL compute a + ~b + 1 with cin ignored.
REQ-018 BUSY: each edge SHALL process one group, LSB group first: 4-bit slice of A, slice of (B or ~B), carry register -> 4 sum bits into working register, group carry-out into carry register.
REQ-019 Within a group, carries c1..c4 SHALL come from lookahead equations on per-bit generate (a&b) and propagate (a^b) and the group carry-in, not from a chain of bit-level ripple stages.
REQ-020 On the edge processing group N-1, FSM SHALL enter DONE and load sum from the working register, cout from group N-1 carry-out, ovf = (carry into bit WIDTH-1) XOR cout.
REQ-021 sum, cout, ovf SHALL change only on entry to DONE (or reset) and hold otherwise; partial results SHALL never be visible on sum.
REQ-022 busy SHALL be 1 exactly in BUSY (N cycles per operation); done SHALL be 1 exactly in DONE (one cycle).
REQ-023 Latency: start accepted at edge E0 -> done high in the cycle after edge E(N).
REQ-024 DONE: start=1 SHALL be accepted as in IDLE (back-to-back, no idle gap); start=0 returns to IDLE.
REQ-025 start and operand changes during BUSY SHALL be ignored and SHALL not affect the in-flight result.
REQ-026 For sub=1, cout=1 means no borrow (a >= b unsigned); cout=0 means borrow.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear working, carry and index registers, regardless of state.
REQ-028 An operation interrupted by reset SHALL be abandoned; no done SHALL pulse for it after rst_n rises.
REQ-029 First start SHALL be accepted at the first rising edge with rst_n high.

Verification (WIDTH=16 unless stated; done 5 cycles after start edge)
REQ-030 a=0x0001, b=0x0001, cin=0, sub=0 -> busy high 4 cycles, done one cycle, sum=0x0002, cout=0, ovf=0.
REQ-031 a=0xFFFF, b=0xFFFF, cin=1, sub=0 -> sum=0xFFFF, cout=1, ovf=0; a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-032 sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-033 Start a=0x1234, b=0x1111; pulse start with a=0xFFFF during BUSY -> single done with sum=0x2345; start held in DONE with a=0x0F0F, b=0x00F1 -> second done 5 cycles later, sum=0x1000, no IDLE cycle between.
REQ-034 rst_n low after 2 BUSY cycles -> busy=0, done=0, sum=0x0000 asynchronously; no done pulse for 10 cycles after release with start=0.
REQ-035 WIDTH=4 instance: a=1011, b=1011, cin=0 -> done 2 cycles after start edge, sum=0110, cout=1, ovf=1; a=1111, b=1111, cin=1 -> sum=1111, cout=1, ovf=0.
